// File: rtl/serial_add_pkg.sv
// Shared types and defaults for the bit-serial adder controller.
package serial_add_pkg;

   localparam int WIDTH_DEFAULT = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

endpackage

// File: rtl/ha_cell.sv
// Single-bit half adder; two of these plus an OR make one full-adder step.
module ha_cell (
   input  logic x,
   input  logic y,
   output logic s,
   output logic c
);

   assign s = x ^ y;
   assign c = x & y;

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial unsigned adder: one bit per cycle, LSB first, result and carry-out
// published with a one-cycle done pulse. state_o exposes the FSM for debug.
module serial_add_ctrl
   import serial_add_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output state_e           state_o
);

   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   // Handshake: start is a level sampled on each rising edge; it is accepted
   // only while busy is low (IDLE). done pulses for one cycle when sum/cout
   // are updated; there is no backpressure on the result.

   state_e            state_q, state_d;
   logic [WIDTH-1:0]  a_q, a_d;
   logic [WIDTH-1:0]  b_q, b_d;
   logic [WIDTH-1:0]  res_q, res_d;
   logic              carry_q, carry_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [WIDTH-1:0]  sum_q, sum_d;
   logic              cout_q, cout_d;
   logic              done_q, done_d;

   logic              hs0, hc0, hc1;
   logic              sum_bit;
   logic              carry_next;
   logic [WIDTH-1:0]  res_shift;
   logic              res_lsb_unused;

   ha_cell u_ha_ab (
      .x (a_q[0]),
      .y (b_q[0]),
      .s (hs0),
      .c (hc0)
   );

   ha_cell u_ha_cin (
      .x (hs0),
      .y (carry_q),
      .s (sum_bit),
      .c (hc1)
   );

   assign carry_next = hc0 | hc1;

   // Sum bits enter at the MSB so after WIDTH shifts the register is aligned;
   // the outgoing LSB is never needed again.
   generate
      if (WIDTH == 1) begin : g_res_w1
         assign res_shift = sum_bit;
      end else begin : g_res_wn
         assign res_shift = {sum_bit, res_q[WIDTH-1:1]};
      end
   endgenerate

   assign res_lsb_unused = res_q[0];

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      carry_d = carry_q;
      cnt_d   = cnt_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      done_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d = RUN;
               a_d     = a;
               b_d     = b;
               carry_d = 1'b0;
               cnt_d   = '0;
            end
         end
         RUN: begin
            a_d     = a_q >> 1;
            b_d     = b_q >> 1;
            res_d   = res_shift;
            carry_d = carry_next;
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == LAST_BIT) begin
               state_d = DONE;
               sum_d   = res_shift;
               cout_d  = carry_next;
               done_d  = 1'b1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         carry_q <= carry_d;
         cnt_q   <= cnt_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         done_q  <= done_d;
      end
   end

   assign busy    = (state_q != IDLE);
   assign done    = done_q;
   assign sum     = sum_q;
   assign cout    = cout_q;
   assign state_o = state_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl: WIDTH=8 vector table and corner sequences,
// plus a WIDTH=1 instance for the single-bit case.
module tb_serial_add_ctrl;
   import serial_add_pkg::*;

   localparam int W = 8;

   // ---------------- clock / reset / DUTs ----------------
   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic [W-1:0] a, b;
   logic         busy, done, cout;
   logic [W-1:0] sum;
   state_e       state;

   logic         start1;
   logic [0:0]   a1, b1, sum1;
   logic         busy1, done1, cout1;
   state_e       state1;

   always #5 clk = ~clk;

   serial_add_ctrl #(.WIDTH(W)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .a       (a),
      .b       (b),
      .busy    (busy),
      .done    (done),
      .sum     (sum),
      .cout    (cout),
      .state_o (state)
   );

   serial_add_ctrl #(.WIDTH(1)) dut1 (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start1),
      .a       (a1),
      .b       (b1),
      .busy    (busy1),
      .done    (done1),
      .sum     (sum1),
      .cout    (cout1),
      .state_o (state1)
   );

   // ---------------- scoreboard ----------------
   logic [W:0] exp_q[$];
   logic [W:0] last_res = '0;
   logic [W:0] mon_e;
   int         n_tests = 0;
   int         n_fail  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && done) begin
         if (exp_q.size() == 0) begin
            check("unexpected_done", 32'd1, 32'd0);
         end else begin
            mon_e = exp_q.pop_front();
            check("sum", 32'(sum), 32'(mon_e[W-1:0]));
            check("cout", 32'(cout), 32'(mon_e[W]));
            last_res = mon_e;
         end
      end
   end

   // ---------------- driver tasks ----------------
   // Called at a negedge with the DUT idle; returns at a negedge, idle again.
   task automatic do_op(input logic [W-1:0] va, input logic [W-1:0] vb,
                        input logic [W:0] e, input bit scramble);
      int n;
      int busy_n;
      a     = va;
      b     = vb;
      start = 1'b1;
      exp_q.push_back(e);
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      a     = W'($urandom);
      b     = W'($urandom);
      check("busy_after_accept", 32'(busy), 32'd1);
      check("state_run", 32'(state), 32'(RUN));
      busy_n = 1;
      n      = 0;
      while (n < 40) begin
         @(posedge clk);
         n++;
         @(negedge clk);
         if (busy) busy_n++;
         if (scramble && n == 1) begin
            a = '0;
            b = '0;
         end
         if (n == 4) check("sum_hold_in_run", 32'({cout, sum}), 32'(last_res));
         if (done) break;
      end
      // Acceptance edge counts as edge 1, so done lands on edge W+1.
      check("latency_edges", 32'(n + 1), 32'(W + 1));
      check("busy_cycles", 32'(busy_n), 32'(W + 1));
      @(posedge clk);
      @(negedge clk);
      check("done_one_cycle", 32'(done), 32'd0);
      check("busy_back_idle", 32'(busy), 32'd0);
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W:0]   exp;
      bit           scramble;
   } vec_t;

   vec_t vecs[12];

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W:0]   exp;
   } pair_t;

   pair_t pairs[3];

   initial begin
      logic [1:0] e1;

      vecs[0] = '{8'h00, 8'h00, 9'h000, 1'b0};
      vecs[1] = '{8'hFF, 8'h01, 9'h100, 1'b0};
      vecs[2] = '{8'hA5, 8'h5A, 9'h0FF, 1'b1};
      vecs[3] = '{8'h80, 8'h80, 9'h100, 1'b0};
      vecs[4] = '{8'h7F, 8'h01, 9'h080, 1'b0};
      vecs[5] = '{8'hFF, 8'hFF, 9'h1FE, 1'b0};
      vecs[6] = '{8'hC8, 8'h64, 9'h12C, 1'b0};
      vecs[7] = '{8'h12, 8'h34, 9'h046, 1'b0};
      for (int i = 8; i < 12; i++) begin
         vecs[i].a        = W'($urandom_range(0, 255));
         vecs[i].b        = W'($urandom_range(0, 255));
         vecs[i].exp      = {1'b0, vecs[i].a} + {1'b0, vecs[i].b};
         vecs[i].scramble = 1'b0;
      end
      pairs[0] = '{8'h3C, 8'h0F, 9'h04B};
      pairs[1] = '{8'hF0, 8'hF0, 9'h1E0};
      pairs[2] = '{8'h01, 8'hFE, 9'h0FF};

      rst_n  = 1'b0;
      start  = 1'b0;
      a      = '0;
      b      = '0;
      start1 = 1'b0;
      a1     = '0;
      b1     = '0;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_sum", 32'(sum), 32'd0);
      check("rst_cout", 32'(cout), 32'd0);
      check("rst_state", 32'(state), 32'(IDLE));
      check("rst_w1_busy", 32'(busy1), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Table-driven operations, back to back
      for (int i = 0; i < 12; i++) begin
         do_op(vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].scramble);
      end

      // start held high: accepts only at k = 0, 10, 20
      for (int k = 0; k < 30; k++) begin
         if (k % 10 == 0) begin
            a = pairs[k / 10].a;
            b = pairs[k / 10].b;
            exp_q.push_back(pairs[k / 10].exp);
         end else begin
            a = W'($urandom);
            b = W'($urandom);
         end
         start = 1'b1;
         @(posedge clk);
         @(negedge clk);
         check("held_done", 32'(done), 32'(k % 10 == 8));
         check("held_busy", 32'(busy), 32'(k % 10 != 9));
      end
      start = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("held_idle_after", 32'(busy), 32'd0);

      // WIDTH=1 instance: done one edge after the acceptance edge
      for (int i = 0; i < 4; i++) begin
         a1     = 1'(i & 1);
         b1     = 1'((i >> 1) & 1);
         e1     = 2'(a1) + 2'(b1);
         start1 = 1'b1;
         @(posedge clk);
         @(negedge clk);
         start1 = 1'b0;
         a1     = ~a1;
         b1     = ~b1;
         check("w1_busy_run", 32'(busy1), 32'd1);
         check("w1_done_early", 32'(done1), 32'd0);
         @(posedge clk);
         @(negedge clk);
         check("w1_done", 32'(done1), 32'd1);
         check("w1_sum", 32'(sum1), 32'(e1[0]));
         check("w1_cout", 32'(cout1), 32'(e1[1]));
         @(posedge clk);
         @(negedge clk);
         check("w1_done_low", 32'(done1), 32'd0);
         check("w1_idle", 32'(busy1), 32'd0);
      end

      // Abort mid-RUN: outputs cleared at once, no done afterwards
      do_op(8'hFF, 8'hFF, 9'h1FE, 1'b0);
      a     = 8'h80;
      b     = 8'h80;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (3) begin
         @(posedge clk);
         @(negedge clk);
      end
      rst_n = 1'b0;
      #1;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      check("abort_sum", 32'(sum), 32'd0);
      check("abort_cout", 32'(cout), 32'd0);
      check("abort_state", 32'(state), 32'(IDLE));
      last_res = '0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 12; k++) begin
         @(posedge clk);
         @(negedge clk);
         check("abort_no_done", 32'(done), 32'd0);
         check("abort_sum_held", 32'({cout, sum}), 32'd0);
      end
      do_op(8'h80, 8'h80, 9'h100, 1'b0);

      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8: operand and result bit width, legal values 1..32.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin an addition, sampled on the rising clk edge.
REQ-005 The block SHALL have port a, input, WIDTH bits: operand A, captured on an accepted start.
REQ-006 The block SHALL have port b, input, WIDTH bits: operand B, captured on an accepted start.
REQ-007 The block SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-008 The block SHALL have port done, output, 1 bit: registered one-cycle pulse marking a result as valid.
REQ-009 The block SHALL have port sum, output, WIDTH bits: result of the last completed addition.
REQ-010 The block SHALL have port cout, output, 1 bit: carry-out of the last completed addition.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-012 In IDLE with start=1 at a rising edge, the block SHALL capture a and b into shift registers, clear the carry flop and the bit counter, and go to RUN.
REQ-013 In IDLE with start=0, the state SHALL remain IDLE.
REQ-014 In RUN, each cycle SHALL process one bit, LSB first.
- Two half-adder cells plus an OR form sum_bit and carry_next from (a_bit, b_bit, carry).
- sum_bit shifts into the internal result register; carry_next loads the carry flop.
- The counter increments by 1.
REQ-015 On the edge that processes bit WIDTH-1, the block SHALL go to DONE.
- The complete result loads into sum.
- The final carry loads into cout.
- done goes high.
REQ-016 From DONE, the block SHALL return to IDLE on the next edge, and done SHALL return low.
REQ-017 Latency SHALL be exactly WIDTH+1 edges from the edge that accepts start to the edge that raises done; done stays high for exactly one cycle.
REQ-018 start asserted in RUN or DONE SHALL be ignored: no capture, no restart, no queuing.
REQ-019 start asserted in the cycle after done, with the state back in IDLE, SHALL be accepted, so back-to-back operations run with one idle cycle between them.
REQ-020 sum and cout SHALL change only on the completion edge and SHALL hold their values during IDLE and during a subsequent RUN.
REQ-021 a and b SHALL be ignored except on the accepting edge; changes to them during RUN SHALL not affect the result.
REQ-022 Arithmetic SHALL be unsigned modulo 2^WIDTH, with the overflow bit on cout.
REQ-023 With WIDTH=1, RUN SHALL last exactly one cycle.

Reset
REQ-024 rst_n=0 SHALL immediately, asynchronously to clk, force the state to IDLE and clear busy, done, sum, cout, the carry flop, the counter and the shift registers to 0.
REQ-025 A reset asserted mid-RUN SHALL abort the operation; no done pulse and no sum or cout update SHALL follow.
REQ-026 After rst_n deasserts, the first rising edge with start=1 SHALL be accepted normally.

Structure
REQ-027 Package serial_add_pkg SHALL hold the state enum (IDLE, RUN, DONE) and the WIDTH default constant.
REQ-028 The single-bit half adder SHALL be a sub-module named ha_cell (inputs x and y; outputs s and c), instantiated twice in the datapath.
REQ-029 The counter SHALL be $clog2(WIDTH+1) bits wide.

Verification
REQ-030 The bench SHALL cover the following directed scenarios, all with WIDTH=8:
- a=0x00, b=0x00, start pulse -> done exactly 9 edges after acceptance; sum=0x00, cout=0.
- a=0xFF, b=0x01 -> sum=0x00, cout=1; busy high for 9 cycles.
- a=0xA5, b=0x5A, with a and b changed to 0x00 on the second RUN cycle -> sum=0xFF, cout=0.
- start held high continuously -> one result every 10 cycles; no start is accepted during RUN or DONE.
- rst_n low on the 4th RUN cycle of a=0x80, b=0x80 -> outputs 0 immediately and no done; after release, a=0x80, b=0x80 -> sum=0x00, cout=1.
- WIDTH=1, a=1, b=1 -> done 2 edges after acceptance; sum=0, cout=1.
